// File: rtl/onehot_decode_stream.sv
// Purpose: decodes an encoded index plus "any active" flag into a one-hot vector, buffered 2 deep.
// Latency: 1 cycle from push edge to out_*; sustains 1 word/cycle with out_ready held high.
// Backpressure: in_ready = buffer not full (registered state only); head holds while out_ready=0.
// Ports: clk/rst_n (sync active-low); in_valid/in_ready/in_idx/in_active upstream handshake;
//        out_valid/out_ready/out_onehot/out_err downstream handshake; err_cnt saturating error count.
module onehot_decode_stream #(
   parameter int IDX_W   = 1,
   parameter int NUM_OUT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IDX_W-1:0]   in_idx,
   input  logic               in_active,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_onehot,
   output logic               out_err,
   output logic [7:0]         err_cnt
);

   // One extra bit so NUM_OUT = 2**IDX_W is representable; the range compare
   // then folds to constant false and drops out of the netlist.
   localparam logic [IDX_W:0] NUM_OUT_V = (IDX_W+1)'(NUM_OUT);

   logic [NUM_OUT-1:0] ent_onehot_q [2];
   logic [NUM_OUT-1:0] ent_onehot_d [2];
   logic               ent_err_q    [2];
   logic               ent_err_d    [2];
   logic               rd_ptr_q, rd_ptr_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic [1:0]         count_q, count_d;
   logic [7:0]         err_cnt_q, err_cnt_d;

   logic               push, pop;
   logic [NUM_OUT-1:0] dec_onehot;
   logic               dec_err;

   assign in_ready   = (count_q != 2'd2);
   assign out_valid  = (count_q != 2'd0);
   assign push       = in_valid & in_ready;
   assign pop        = out_valid & out_ready;
   assign out_onehot = out_valid ? ent_onehot_q[rd_ptr_q] : '0;
   assign out_err    = out_valid ? ent_err_q[rd_ptr_q] : 1'b0;
   assign err_cnt    = err_cnt_q;

   always_comb begin
      dec_onehot = '0;
      dec_err    = 1'b0;
      if (in_active) begin
         if ({1'b0, in_idx} >= NUM_OUT_V) begin
            dec_err = 1'b1;
         end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
               if ({1'b0, in_idx} == (IDX_W+1)'(i)) begin
                  dec_onehot[i] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      ent_onehot_d = ent_onehot_q;
      ent_err_d    = ent_err_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      err_cnt_d    = err_cnt_q;

      if (push) begin
         ent_onehot_d[wr_ptr_q] = dec_onehot;
         ent_err_d[wr_ptr_q]    = dec_err;
         wr_ptr_d               = ~wr_ptr_q;
         if (dec_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      // Push and pop together leave occupancy unchanged.
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_onehot_q <= '{default: '0};
         ent_err_q    <= '{default: 1'b0};
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         err_cnt_q    <= 8'd0;
      end else begin
         ent_onehot_q <= ent_onehot_d;
         ent_err_q    <= ent_err_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_onehot_decode_stream.sv
// Purpose: self-checking bench for onehot_decode_stream (default and IDX_W=2/NUM_OUT=3 instances).
// Latency: model predicts out_* one cycle after each accepted word.
// Backpressure: model occupancy drives expected in_ready/out_valid.
module tb_onehot_decode_stream;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: defaults (IDX_W=1, NUM_OUT=2)
   logic       a_in_valid, a_in_ready, a_in_active, a_out_valid, a_out_ready, a_out_err;
   logic [0:0] a_in_idx;
   logic [1:0] a_out_onehot;
   logic [7:0] a_err_cnt;

   // Instance B: IDX_W=2, NUM_OUT=3
   logic       b_in_valid, b_in_ready, b_in_active, b_out_valid, b_out_ready, b_out_err;
   logic [1:0] b_in_idx;
   logic [2:0] b_out_onehot;
   logic [7:0] b_err_cnt;

   onehot_decode_stream u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_idx(a_in_idx), .in_active(a_in_active),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_onehot(a_out_onehot),
      .out_err(a_out_err), .err_cnt(a_err_cnt)
   );

   onehot_decode_stream #(.IDX_W(2), .NUM_OUT(3)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_idx(b_in_idx), .in_active(b_in_active),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_onehot(b_out_onehot),
      .out_err(b_out_err), .err_cnt(b_err_cnt)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model entry: bit 7 = err, low bits = one-hot vector.
   function automatic logic [7:0] mdl_decode(input int n, input int idx, input bit act);
      if (!act)     return 8'h00;
      if (idx >= n) return 8'h80;
      return 8'(1 << idx);
   endfunction

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int ecnt_a = 0;
   int ecnt_b = 0;

   always @(posedge clk) begin
      bit push, pop;
      logic [7:0] e;
      if (!rst_n) begin
         qa.delete();
         ecnt_a = 0;
      end else begin
         push = a_in_valid && (qa.size() < 2);
         pop  = a_out_ready && (qa.size() > 0);
         e    = mdl_decode(2, int'(a_in_idx), a_in_active);
         if (pop) void'(qa.pop_front());
         if (push) begin
            qa.push_back(e);
            if (e[7] && ecnt_a < 255) ecnt_a++;
         end
      end
   end

   always @(posedge clk) begin
      bit push, pop;
      logic [7:0] e;
      if (!rst_n) begin
         qb.delete();
         ecnt_b = 0;
      end else begin
         push = b_in_valid && (qb.size() < 2);
         pop  = b_out_ready && (qb.size() > 0);
         e    = mdl_decode(3, int'(b_in_idx), b_in_active);
         if (pop) void'(qb.pop_front());
         if (push) begin
            qb.push_back(e);
            if (e[7] && ecnt_b < 255) ecnt_b++;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [7:0] ha, hb;
      if (chk_en) begin
         ha = (qa.size() != 0) ? qa[0] : 8'h00;
         hb = (qb.size() != 0) ? qb[0] : 8'h00;
         chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
         chk("a_in_ready", 32'(a_in_ready), 32'(qa.size() != 2));
         chk("a_out_onehot", 32'(a_out_onehot), 32'(ha[1:0]));
         chk("a_out_err", 32'(a_out_err), 32'(ha[7]));
         chk("a_err_cnt", 32'(a_err_cnt), 32'(ecnt_a));
         chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
         chk("b_in_ready", 32'(b_in_ready), 32'(qb.size() != 2));
         chk("b_out_onehot", 32'(b_out_onehot), 32'(hb[2:0]));
         chk("b_out_err", 32'(b_out_err), 32'(hb[7]));
         chk("b_err_cnt", 32'(b_err_cnt), 32'(ecnt_b));
      end
   end

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input bit v, input int idx, input bit act);
      a_in_valid  = v;
      a_in_idx    = 1'(idx);
      a_in_active = act;
   endtask

   task automatic drive_b(input bit v, input int idx, input bit act);
      b_in_valid  = v;
      b_in_idx    = 2'(idx);
      b_in_active = act;
   endtask

   initial begin
      rst_n = 1'b0;
      drive_a(0, 0, 0);
      drive_b(0, 0, 0);
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;

      // Reset defaults
      cyc();
      chk_en = 1'b1;
      cyc();
      chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_out_onehot", 32'(a_out_onehot), 32'd0);
      chk("rst_a_err_cnt", 32'(a_err_cnt), 32'd0);
      chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      rst_n = 1'b1;

      // Basic decode
      drive_a(1, 1, 1);
      cyc();
      chk("dec_idx1", 32'(a_out_onehot), 32'h2);
      chk("dec_idx1_valid", 32'(a_out_valid), 32'd1);
      drive_a(1, 0, 1);
      cyc();
      chk("dec_idx0", 32'(a_out_onehot), 32'h1);
      drive_a(1, 1, 0);
      cyc();
      chk("dec_inactive", 32'(a_out_onehot), 32'h0);
      chk("dec_inactive_err", 32'(a_out_err), 32'd0);
      chk("dec_inactive_valid", 32'(a_out_valid), 32'd1);
      drive_a(0, 0, 0);
      cyc();

      // Backpressure
      a_out_ready = 1'b0;
      drive_a(1, 0, 1);
      cyc();
      chk("bp_ready_after_1", 32'(a_in_ready), 32'd1);
      drive_a(1, 1, 1);
      cyc();
      chk("bp_ready_full", 32'(a_in_ready), 32'd0);
      drive_a(1, 1, 1);  // presented while full: must be ignored
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_hold", 32'(a_out_onehot), 32'h1);
      end
      drive_a(0, 0, 0);
      a_out_ready = 1'b1;
      cyc();
      chk("bp_pop1_head", 32'(a_out_onehot), 32'h2);
      chk("bp_pop1_ready", 32'(a_in_ready), 32'd1);
      cyc();
      chk("bp_empty", 32'(a_out_valid), 32'd0);

      // Streaming: alternating idx, one output per cycle, occupancy never 2
      for (int i = 0; i < 20; i++) begin
         drive_a(1, i % 2, 1);
         cyc();
         chk("stream_data", 32'(a_out_onehot), (i % 2) ? 32'h2 : 32'h1);
         chk("stream_ready", 32'(a_in_ready), 32'd1);
      end
      drive_a(0, 0, 0);
      cyc();

      // Error path on IDX_W=2, NUM_OUT=3
      drive_b(1, 3, 1);
      cyc();
      chk("err_onehot", 32'(b_out_onehot), 32'h0);
      chk("err_flag", 32'(b_out_err), 32'd1);
      chk("err_cnt_1", 32'(b_err_cnt), 32'd1);
      drive_b(1, 2, 1);
      cyc();
      chk("idx2_onehot", 32'(b_out_onehot), 32'h4);
      chk("idx2_err", 32'(b_out_err), 32'd0);
      chk("idx2_cnt", 32'(b_err_cnt), 32'd1);
      for (int i = 0; i < 300; i++) begin
         drive_b(1, 3, 1);
         cyc();
         if (i == 249) chk("err_cnt_251", 32'(b_err_cnt), 32'd251);
      end
      drive_b(0, 0, 0);
      cyc();
      chk("err_cnt_sat", 32'(b_err_cnt), 32'd255);

      // Mid-stream reset
      a_out_ready = 1'b0;
      drive_a(1, 1, 1);
      cyc();
      drive_a(1, 0, 1);
      cyc();
      chk("mr_full", 32'(a_in_ready), 32'd0);
      rst_n = 1'b0;
      drive_a(1, 1, 1);
      drive_b(1, 2, 1);
      cyc();
      rst_n = 1'b1;
      drive_a(0, 0, 0);
      drive_b(0, 0, 0);
      a_out_ready = 1'b1;
      chk("mr_a_valid", 32'(a_out_valid), 32'd0);
      chk("mr_a_ready", 32'(a_in_ready), 32'd1);
      chk("mr_b_valid", 32'(b_out_valid), 32'd0);
      chk("mr_b_cnt", 32'(b_err_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mr_no_ghost_a", 32'(a_out_valid), 32'd0);
         chk("mr_no_ghost_b", 32'(b_out_valid), 32'd0);
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_decode_stream.md
# onehot_decode_stream

Registered stream decoder: the inverse of the team's priority encoders. Accepts an encoded index plus an "any active" flag over a valid/ready handshake, and delivers the matching one-hot vector downstream through a 2-entry buffer. Out-of-range codes are flagged and counted. Sits between an encoder stage (e.g. `priority_encode_*`) and one-hot consumers such as grant lines or enables.

## Interface
- `IDX_W`, default 1: encoded index width.
- `NUM_OUT`, default 2: one-hot output width; legal range 2..2**IDX_W.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block can accept a word this cycle.
- `in_idx` input IDX_W: encoded index (the encoder's `out`).
- `in_active` input 1: encoder's `valid`. 0 means no line set.
- `out_valid` output 1: head entry present.
- `out_ready` input 1: downstream accepts.
- `out_onehot` output NUM_OUT: decoded vector of the head entry.
- `out_err` output 1: head entry had `in_active`=1 with `in_idx` >= NUM_OUT.
- `err_cnt` output 8: saturating count of accepted error words.

## Operation
- **Push.** `push = in_valid & in_ready`. On push, decode and store into the buffer:
  - `in_active`=0 stores onehot=0, err=0.
  - `in_active`=1 with `in_idx` < NUM_OUT stores onehot bit[in_idx]=1 and all other bits 0, err=0.
  - `in_active`=1 with `in_idx` >= NUM_OUT stores onehot=0, err=1.
- **Pop.** `pop = out_valid & out_ready` removes the head.
- **Buffer.** 2 entries, with a read pointer, a write pointer and a 2-bit occupancy count (0..2). Pointers wrap 1 -> 0.
- **Ready/valid.**
  - `in_ready` = (count != 2). It is registered-state derived only, with no combinational path from `out_ready`.
  - `out_valid` = (count != 0).
- **Simultaneous push and pop.**
  - Count unchanged; both pointers advance.
  - Legal only when count is 1. At count 0 there is nothing to pop; at count 2 there is no push.
- **Output data.** `out_onehot` and `out_err` present the head entry when `out_valid`=1. They are forced to 0 when `out_valid`=0.
- **Stability.** While `out_valid`=1 and `out_ready`=0, `out_onehot` and `out_err` hold their values.
- **Error count.** `err_cnt` increments by 1 on each push whose stored err=1. It saturates at 255 and never wraps.
- **Ignored inputs.** Inputs are ignored when `in_valid`=0 or `in_ready`=0.
- **Reset.**
  - All outputs reset to 0: `out_valid`=0, `out_onehot`=0, `out_err`=0, `err_cnt`=0.
  - `in_ready` reads 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered entries. The word presented in the reset cycle is not accepted.
- **Parameters.** When NUM_OUT = 2**IDX_W, err can never be set. The compare logic is still present and must synthesize away.

## Timing
- Latency is 1 cycle: a word pushed at edge N is visible on `out_*` after edge N, with `out_valid`=1.
- Throughput is 1 word/cycle when `out_ready` is held at 1. Occupancy stays at 1 with a push and pop every cycle.
- Backpressure:
  - With `out_ready`=0, two words are accepted, then `in_ready` drops to 0 after the second push edge.
  - `in_ready` returns to 1 the cycle after the first pop.
- `err_cnt` updates on the same edge as the push that caused it.
- There are no combinational input-to-output paths except the `out_valid`/`in_ready` derivation from registered state.

## Test plan
- **Reset defaults.** Hold `rst_n`=0 for 2 cycles -> `out_valid`=0, `out_onehot`=0, `err_cnt`=0, `in_ready`=1.
- **Basic decode, defaults, `out_ready`=1.**
  - Push idx=1, active=1 -> next cycle `out_onehot`=2'b10.
  - Push idx=0, active=1 -> `out_onehot`=2'b01.
  - Push active=0 -> `out_onehot`=2'b00, `out_err`=0.
- **Backpressure.**
  - `out_ready`=0, push idx=0 then idx=1 -> `in_ready`=0; head holds 2'b01 for 5 cycles.
  - Raise `out_ready` -> pops 2'b01 then 2'b10 in order; `in_ready`=1 one cycle after the first pop.
- **Streaming.** Continuous pushes of alternating idx 0/1 with `out_ready`=1 for 20 cycles -> 20 outputs in order, no bubbles, occupancy never exceeds 1.
- **Error path, IDX_W=2, NUM_OUT=3.**
  - Push idx=3, active=1 -> `out_onehot`=3'b000, `out_err`=1, `err_cnt`=1.
  - Push idx=2, active=1 -> `out_onehot`=3'b100, `err_cnt` stays 1.
  - Push 300 error words -> `err_cnt`=255.
- **Mid-stream reset.** Fill both entries, assert `rst_n`=0 for one cycle with `in_valid`=1 -> `out_valid`=0, `err_cnt`=0, and the reset-cycle word is never output.
